// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter
// Shares the single .text code-memory port between instruction fetch (read-only)
// and the loader/debug port (read/write). Fetch has fixed priority, but a loader
// that has lost STARVE_LIMIT arbitrations in a row is forced through next.
// Each transaction takes three cycles: IDLE (grant), ACCESS (one memory strobe),
// RESP (one acknowledge pulse to the owner).
module code_mem_arbiter #(
    parameter logic [63:0] BEGINNING_TEXT = 64'h0000_0000_0040_0000,
    parameter logic [63:0] END_TEXT       = 64'h0000_0000_0040_3FFC,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFetchReq,
    input  logic [63:0] iFetchAddr,
    output logic        oFetchAck,
    output logic [31:0] oFetchData,
    output logic        oFetchErr,
    input  logic        iLdReq,
    input  logic        iLdWe,
    input  logic [63:0] iLdAddr,
    input  logic [63:0] iLdWData,
    input  logic [7:0]  iLdBE,
    output logic        oLdAck,
    output logic [31:0] oLdRData,
    output logic        oLdErr,
    output logic        oMemRE,
    output logic        oMemWE,
    output logic [7:0]  oMemBE,
    output logic [63:0] oMemAddr,
    output logic [63:0] oMemWData,
    input  logic [31:0] iMemRData,
    output logic        oBusy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t           r_state;
    logic [CNT_W-1:0] r_starve;
    logic             r_owner_ld;
    logic             r_we;
    logic             r_err;
    logic             r_mem_re;
    logic             r_mem_we;
    logic [7:0]       r_mem_be;
    logic [63:0]      r_mem_addr;
    logic [63:0]      r_mem_wdata;
    logic             r_fetch_ack;
    logic             r_ld_ack;

    logic             w_any_req;
    logic             w_grant_ld;
    logic [63:0]      w_sel_addr;
    logic             w_sel_we;
    logic             w_sel_err;

    // Range and word-alignment check applied to the granted address.
    function automatic logic addr_err(input logic [63:0] a);
        return (a < BEGINNING_TEXT) || (a > END_TEXT) || (a[1:0] != 2'b00);
    endfunction

    // Arbitration: fetch wins unless the loader has been passed over STARVE_LIMIT times.
    always_comb begin
        w_any_req  = iFetchReq | iLdReq;
        w_grant_ld = iLdReq & (~iFetchReq | (r_starve == LIMIT_C));
        w_sel_addr = w_grant_ld ? iLdAddr : iFetchAddr;
        w_sel_we   = w_grant_ld & iLdWe;
        w_sel_err  = addr_err(w_sel_addr);
    end

    // Transaction FSM with registered strobes, acknowledges and starvation counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_owner_ld  <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fetch_ack <= 1'b0;
            r_ld_ack    <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses; the memory bus idles at zero.
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fetch_ack <= 1'b0;
            r_ld_ack    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_ACCESS;
                        r_owner_ld <= w_grant_ld;
                        r_we       <= w_sel_we;
                        r_err      <= w_sel_err;
                        if (!w_sel_err) begin
                            r_mem_addr <= w_sel_addr;
                            if (w_sel_we) begin
                                r_mem_we    <= 1'b1;
                                r_mem_be    <= iLdBE;
                                r_mem_wdata <= iLdWData;
                            end else begin
                                r_mem_re <= 1'b1;
                            end
                        end
                        // Count only fetch wins that leave a loader waiting.
                        if (w_grant_ld || !iLdReq) begin
                            r_starve <= '0;
                        end else if (r_starve != LIMIT_C) begin
                            r_starve <= r_starve + CNT_W'(1);
                        end
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_fetch_ack <= ~r_owner_ld;
                    r_ld_ack    <= r_owner_ld;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data arrives from memory during RESP, so it is steered straight to the owner.
    always_comb begin
        oMemRE     = r_mem_re & ~iRST;
        oMemWE     = r_mem_we & ~iRST;
        oMemBE     = r_mem_be;
        oMemAddr   = r_mem_addr;
        oMemWData  = r_mem_wdata;
        oFetchAck  = r_fetch_ack;
        oLdAck     = r_ld_ack;
        oFetchErr  = r_fetch_ack & r_err;
        oLdErr     = r_ld_ack & r_err;
        oFetchData = (r_fetch_ack & ~r_we & ~r_err) ? iMemRData : 32'h0;
        oLdRData   = (r_ld_ack & ~r_we & ~r_err) ? iMemRData : 32'h0;
        oBusy      = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Bench for code_mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_code_mem_arbiter;

    localparam logic [63:0] BEG   = 64'h0000_0000_0040_0000;
    localparam logic [63:0] END_A = 64'h0000_0000_0040_3FFC;
    localparam int          LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        iFetchReq;
    logic [63:0] iFetchAddr;
    logic        oFetchAck;
    logic [31:0] oFetchData;
    logic        oFetchErr;
    logic        iLdReq;
    logic        iLdWe;
    logic [63:0] iLdAddr;
    logic [63:0] iLdWData;
    logic [7:0]  iLdBE;
    logic        oLdAck;
    logic [31:0] oLdRData;
    logic        oLdErr;
    logic        oMemRE;
    logic        oMemWE;
    logic [7:0]  oMemBE;
    logic [63:0] oMemAddr;
    logic [63:0] oMemWData;
    logic [31:0] mem_rdata;
    logic        oBusy;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int starve_m = 0;

    code_mem_arbiter dut (
        .iCLK(clk), .iRST(rst),
        .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr),
        .oFetchAck(oFetchAck), .oFetchData(oFetchData), .oFetchErr(oFetchErr),
        .iLdReq(iLdReq), .iLdWe(iLdWe), .iLdAddr(iLdAddr), .iLdWData(iLdWData), .iLdBE(iLdBE),
        .oLdAck(oLdAck), .oLdRData(oLdRData), .oLdErr(oLdErr),
        .oMemRE(oMemRE), .oMemWE(oMemWE), .oMemBE(oMemBE), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .iMemRData(mem_rdata), .oBusy(oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory contents as a pure function of address.
    function automatic logic [31:0] memval(input logic [63:0] a);
        if (a == 64'h40_0000) return 32'h8B02_0020;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read memory: data valid the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        mem_rdata <= oMemRE ? memval(oMemAddr) : 32'hDEAD_BEEF;
        if (oMemWE) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        freq;
        logic [63:0] faddr;
        logic        lreq;
        logic        lwe;
        logic [63:0] laddr;
        logic [63:0] lwdata;
        logic [7:0]  lbe;
        logic        e_re;
        logic        e_we;
        logic [63:0] e_addr;
        logic        e_fack;
        logic        e_lack;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic fr, input logic [63:0] fa,
                                input logic lr, input logic lw, input logic [63:0] la,
                                input logic [63:0] ld, input logic [7:0] lb,
                                input logic ere, input logic ewe, input logic [63:0] ea,
                                input logic efa, input logic ela, input logic [31:0] ed,
                                input logic ee);
        vec_t v;
        v.name = nm; v.freq = fr; v.faddr = fa; v.lreq = lr; v.lwe = lw; v.laddr = la;
        v.lwdata = ld; v.lbe = lb; v.e_re = ere; v.e_we = ewe; v.e_addr = ea;
        v.e_fack = efa; v.e_lack = ela; v.e_data = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; iFetchReq = 1'b0; iLdReq = 1'b0; iLdWe = 1'b0;
        iFetchAddr = '0; iLdAddr = '0; iLdWData = '0; iLdBE = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        starve_m = 0;
    endtask

    // Reference model: decides the winner from the arbitration rules and derives the response.
    task automatic model(inout vec_t v);
        bit          ld_wins, bad, wr;
        logic [63:0] a;
        ld_wins = v.lreq && (!v.freq || starve_m == LIMIT);
        if (v.freq || v.lreq) begin
            if (ld_wins || !v.lreq) starve_m = 0;
            else if (starve_m < LIMIT) starve_m++;
        end
        a   = ld_wins ? v.laddr : v.faddr;
        bad = (a < BEG) || (a > END_A) || (a % 4 != 0);
        wr  = ld_wins && v.lwe;
        v.e_re   = (v.freq || v.lreq) && !bad && !wr;
        v.e_we   = !bad && wr;
        v.e_addr = bad ? 64'h0 : a;
        v.e_fack = v.freq && !ld_wins;
        v.e_lack = ld_wins;
        v.e_err  = bad;
        v.e_data = (bad || wr) ? 32'h0 : memval(a);
    endtask

    // One transaction from an IDLE cycle; entered and left at posedge+1.
    task automatic apply(input vec_t v, input bit disturb);
        int wc0;
        bit any;
        any = v.freq | v.lreq;
        wc0 = wr_cnt;
        iFetchReq = v.freq; iFetchAddr = v.faddr; iLdReq = v.lreq; iLdWe = v.lwe;
        iLdAddr = v.laddr; iLdWData = v.lwdata; iLdBE = v.lbe;
        @(posedge clk); #1;
        if (disturb) begin
            iFetchReq = 1'b0; iLdReq = 1'b0; iLdWe = ~iLdWe;
            iLdAddr = iLdAddr + 64'h40; iFetchAddr = iFetchAddr + 64'h40;
            iLdWData = ~iLdWData; iLdBE = ~iLdBE;
        end
        @(negedge clk);
        if (!any) begin
            chk({v.name, "_idle_busy"}, 64'(oBusy), 64'(0));
            chk({v.name, "_idle_strobe"}, 64'({oMemRE, oMemWE}), 64'(0));
            @(posedge clk); #1;
            return;
        end
        chk({v.name, "_re"}, 64'(oMemRE), 64'(v.e_re));
        chk({v.name, "_we"}, 64'(oMemWE), 64'(v.e_we));
        chk({v.name, "_addr"}, oMemAddr, v.e_addr);
        chk({v.name, "_acc_ack"}, 64'({oFetchAck, oLdAck}), 64'(0));
        chk({v.name, "_acc_busy"}, 64'(oBusy), 64'(1));
        if (v.e_we) begin
            chk({v.name, "_wdata"}, oMemWData, v.lwdata);
            chk({v.name, "_be"}, 64'(oMemBE), 64'(v.lbe));
        end
        @(posedge clk); #1;
        iFetchReq = 1'b0; iLdReq = 1'b0;
        @(negedge clk);
        chk({v.name, "_fack"}, 64'(oFetchAck), 64'(v.e_fack));
        chk({v.name, "_lack"}, 64'(oLdAck), 64'(v.e_lack));
        chk({v.name, "_fdata"}, 64'(oFetchData), 64'(v.e_fack ? v.e_data : 32'h0));
        chk({v.name, "_ldata"}, 64'(oLdRData), 64'(v.e_lack ? v.e_data : 32'h0));
        chk({v.name, "_ferr"}, 64'(oFetchErr), 64'(v.e_fack & v.e_err));
        chk({v.name, "_lerr"}, 64'(oLdErr), 64'(v.e_lack & v.e_err));
        chk({v.name, "_resp_strobe"}, 64'({oMemRE, oMemWE}), 64'(0));
        @(posedge clk); #1;
        chk({v.name, "_wr_count"}, 64'(wr_cnt - wc0), 64'(v.e_we));
        chk({v.name, "_done_busy"}, 64'(oBusy), 64'(0));
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = BEG + 64'($urandom_range(0, 4095)) * 64'd4;
        case ($urandom_range(0, 7))
            0:       return BEG;
            1:       return END_A;
            2:       return BEG - 64'd4;
            3:       return END_A + 64'd4;
            4:       return a + 64'($urandom_range(1, 3));
            5:       return {32'h0, $urandom};
            default: return a;
        endcase
    endfunction

    vec_t tbl[$];
    vec_t v;
    byte  got[$];
    byte  expq[$];

    initial begin
        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_acks", 64'({oFetchAck, oLdAck, oFetchErr, oLdErr}), 64'(0));
        chk("rst_strobes", 64'({oMemRE, oMemWE}), 64'(0));
        chk("rst_addr", oMemAddr, 64'h0);
        chk("rst_wdata", oMemWData, 64'h0);
        chk("rst_be", 64'(oMemBE), 64'(0));
        chk("rst_data", 64'({oFetchData, oLdRData}), 64'(0));
        chk("rst_busy", 64'(oBusy), 64'(0));
        @(posedge clk); #1;

        // Directed vector table
        tbl.push_back(mk("T1_fetch", 1, BEG, 0, 0, 0, 0, 0, 1, 0, BEG, 1, 0, 32'h8B02_0020, 0));
        tbl.push_back(mk("T2_ldwr", 0, 0, 1, 1, BEG + 64'h10, 64'h1234, 8'h0F, 0, 1, BEG + 64'h10, 0, 1, 32'h0, 0));
        tbl.push_back(mk("T4_below", 1, 64'h3F_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk("T4_above", 1, 64'h40_4000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk("T4_misal", 1, 64'h40_0002, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk("T4_end_ok", 1, END_A, 0, 0, 0, 0, 0, 1, 0, END_A, 1, 0, memval(END_A), 0));
        tbl.push_back(mk("ld_rd", 0, 0, 1, 0, BEG + 64'h20, 64'hFFFF, 8'hFF, 1, 0, BEG + 64'h20, 0, 1, memval(BEG + 64'h20), 0));
        tbl.push_back(mk("ld_wr_end", 0, 0, 1, 1, END_A, 64'hCAFE_0000_BEEF, 8'hF0, 0, 1, END_A, 0, 1, 32'h0, 0));
        tbl.push_back(mk("ld_wr_over", 0, 0, 1, 1, END_A + 64'd4, 64'h55, 8'hFF, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk("ld_rd_under", 0, 0, 1, 0, BEG - 64'd4, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk("both_fetch", 1, BEG + 64'h4, 1, 1, BEG + 64'h8, 64'h77, 8'hFF, 1, 0, BEG + 64'h4, 1, 0, memval(BEG + 64'h4), 0));
        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // T3: both requests held continuously; record grant order
        reset_dut();
        iFetchReq = 1'b1; iFetchAddr = BEG + 64'h8;
        iLdReq = 1'b1; iLdWe = 1'b0; iLdAddr = BEG + 64'hC;
        for (int c = 0; c < 45 && got.size() < 10; c++) begin
            @(negedge clk);
            if (oFetchAck) got.push_back("F");
            if (oLdAck) got.push_back("L");
        end
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 10; i++) begin
                if (cnt == LIMIT) begin expq.push_back("L"); cnt = 0; end
                else begin expq.push_back("F"); cnt++; end
            end
        end
        chk("T3_grant_count", 64'(got.size()), 64'(10));
        for (int i = 0; i < 10 && i < got.size(); i++) chk("T3_grant", 64'(got[i]), 64'(expq[i]));
        @(posedge clk); #1;
        iFetchReq = 1'b0; iLdReq = 1'b0;

        // T5: reset during ACCESS of a loader write
        reset_dut();
        begin
            int wc0;
            wc0 = wr_cnt;
            iLdReq = 1'b1; iLdWe = 1'b1; iLdAddr = BEG + 64'h30; iLdWData = 64'hABCD; iLdBE = 8'hFF;
            @(posedge clk); #1;
            rst = 1'b1; iLdReq = 1'b0;
            @(negedge clk);
            chk("T5_no_we_in_rst", 64'(oMemWE), 64'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("T5_busy", 64'(oBusy), 64'(0));
            chk("T5_acks", 64'({oFetchAck, oLdAck}), 64'(0));
            chk("T5_bus", 64'(oMemAddr | oMemWData | 64'(oMemBE)), 64'(0));
            @(posedge clk); #1;
            @(negedge clk);
            chk("T5_acks_late", 64'({oFetchAck, oLdAck}), 64'(0));
            chk("T5_wr_count", 64'(wr_cnt - wc0), 64'(0));
            @(posedge clk); #1;
        end

        // T6: loader drops request (and changes inputs) after grant
        reset_dut();
        apply(mk("T6_drop", 0, 0, 1, 0, BEG + 64'h28, 0, 0, 1, 0, BEG + 64'h28, 0, 1, memval(BEG + 64'h28), 0), 1'b1);

        // T6b: arbitration with no loader request clears the starvation count
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            v = mk("T6b_both", 1, BEG + 64'h4, 1, 0, BEG + 64'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            model(v);
            apply(v, 1'b0);
        end
        v = mk("T6b_fonly", 1, BEG + 64'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model(v);
        apply(v, 1'b0);
        v = mk("T6b_after", 1, BEG + 64'h14, 1, 0, BEG + 64'h18, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model(v);
        apply(v, 1'b0);

        // Randomized transactions against the reference model
        reset_dut();
        for (int i = 0; i < 120; i++) begin
            v = mk("rnd", ($urandom_range(0, 3) != 0), rand_addr(),
                   ($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(),
                   {$urandom, $urandom}, 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
            model(v);
            apply(v, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
